packet_framer: RTL and testbench

Upstream source stage for the router: accepts a send request (destination, length) plus a payload byte stream, buffers the whole payload, then emits one contiguous framed packet on the router's byte input (`packet_in` / `packet_valid_i`). It honours the router's `stop_packet_send` back-pressure. Store-and-forward buffering guarantees `packet_valid_o` never gaps mid-packet.

---
 rtl/packet_framer.sv | 247 ++++++++++++++++++++++++
 tb/tb_packet_framer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/packet_framer.sv
// Store-and-forward source stage: buffers one payload, then emits header/length/payload
// as a contiguous frame into the router. Define PACKET_PARITY_EN to append an XOR parity byte.
module packet_framer #(
  parameter int                UWIDTH  = 8,
  parameter int                MAX_LEN = 16,
  parameter int                LEN_W   = 5,
  parameter int                BUF_AW  = 4,
  parameter logic [UWIDTH-1:0] TS1     = 8'd0,
  parameter logic [UWIDTH-1:0] TS2     = 8'd1,
  parameter logic [UWIDTH-1:0] TS3     = 8'd2
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        req_dest,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_ready,
  input  logic              data_valid,
  input  logic [UWIDTH-1:0] data_in,
  output logic              data_ready,
  input  logic              stop_packet_send,
  output logic              packet_valid_o,
  output logic [UWIDTH-1:0] packet_out,
  output logic              err_o,
  output logic              busy
);

  localparam int                DEPTH     = 1 << BUF_AW;
  localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HDR,
    LEN,
    DATA
`ifdef PACKET_PARITY_EN
    ,
    PAR
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          dest_q, dest_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    cnt_inc;
  logic [BUF_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [BUF_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic                pv_q, pv_d;
  logic [UWIDTH-1:0]   pout_q, pout_d;
  logic                err_q, err_d;

  logic [UWIDTH-1:0]   mem [DEPTH];
  logic                wr_en;
  logic [UWIDTH-1:0]   rd_data;
  logic [UWIDTH-1:0]   hdr_byte;
  logic [UWIDTH-1:0]   len_byte;
  logic                xfer;
  logic                req_bad;

  // Single load path into the output register; parity taps the same path.
  logic                ld_en;
  logic [UWIDTH-1:0]   ld_byte;

`ifdef PACKET_PARITY_EN
  logic [UWIDTH-1:0]   par_q, par_d;
`endif

  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign rd_data  = mem[rd_ptr_q];
  assign len_byte = UWIDTH'(len_q);
  assign xfer     = pv_q && !stop_packet_send;
  assign req_bad  = (req_dest > 2'd2) || (req_len == '0) || (req_len > MAX_LEN_L);

  always_comb begin
    case (dest_q)
      2'd0:    hdr_byte = TS1;
      2'd1:    hdr_byte = TS2;
      default: hdr_byte = TS3;
    endcase
  end

  assign req_ready      = (state_q == IDLE) && !rst;
  assign data_ready     = (state_q == LOAD);
  assign busy           = (state_q != IDLE);
  assign packet_valid_o = pv_q;
  assign packet_out     = pout_q;
  assign err_o          = err_q;

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pv_d     = pv_q;
    pout_d   = pout_q;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    ld_en    = 1'b0;
    ld_byte  = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            dest_d   = req_dest;
            len_d    = req_len;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = LOAD;
          end
        end
      end

      LOAD: begin
        if (data_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + BUF_AW'(1);
          if (cnt_inc == len_q) begin
            cnt_d    = '0;
            rd_ptr_d = '0;
            pv_d     = 1'b1;
            ld_en    = 1'b1;
            ld_byte  = hdr_byte;
            state_d  = HDR;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      HDR: begin
        if (xfer) begin
          ld_en   = 1'b1;
          ld_byte = len_byte;
          state_d = LEN;
        end
      end

      LEN: begin
        if (xfer) begin
          ld_en    = 1'b1;
          ld_byte  = rd_data;
          rd_ptr_d = rd_ptr_q + BUF_AW'(1);
          cnt_d    = '0;
          state_d  = DATA;
        end
      end

      DATA: begin
        if (xfer) begin
          if (cnt_inc == len_q) begin
`ifdef PACKET_PARITY_EN
            ld_en   = 1'b1;
            ld_byte = par_q;
            state_d = PAR;
`else
            pv_d    = 1'b0;
            pout_d  = '0;
            state_d = IDLE;
`endif
          end else begin
            ld_en    = 1'b1;
            ld_byte  = rd_data;
            rd_ptr_d = rd_ptr_q + BUF_AW'(1);
            cnt_d    = cnt_inc;
          end
        end
      end

`ifdef PACKET_PARITY_EN
      PAR: begin
        if (xfer) begin
          pv_d    = 1'b0;
          pout_d  = '0;
          state_d = IDLE;
        end
      end
`endif

      default: begin
        pv_d    = 1'b0;
        pout_d  = '0;
        state_d = IDLE;
      end
    endcase

    if (ld_en) begin
      pout_d = ld_byte;
    end
  end

`ifdef PACKET_PARITY_EN
  // Header load restarts the accumulator; later loads fold in each presented byte.
  always_comb begin
    par_d = par_q;
    if (ld_en) begin
      par_d = (state_q == LOAD) ? ld_byte : (par_q ^ ld_byte);
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_ff @(posedge clk1) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dest_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pv_q     <= 1'b0;
      pout_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pv_q     <= pv_d;
      pout_q   <= pout_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// Directed bench for packet_framer: frame contents, stalls, rejects, reset and load gaps.
module tb_packet_framer;

  logic       clk1 = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_dest;
  logic [4:0] req_len;
  logic       req_ready;
  logic       data_valid;
  logic [7:0] data_in;
  logic       data_ready;
  logic       stop_packet_send;
  logic       packet_valid_o;
  logic [7:0] packet_out;
  logic       err_o;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] pay   [0:15];
  logic [7:0] exp_b [0:18];

  packet_framer #(
    .UWIDTH (8),
    .MAX_LEN(16),
    .LEN_W  (5),
    .BUF_AW (4),
    .TS1    (8'd0),
    .TS2    (8'd1),
    .TS3    (8'd2)
  ) dut (
    .clk1            (clk1),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_dest        (req_dest),
    .req_len         (req_len),
    .req_ready       (req_ready),
    .data_valid      (data_valid),
    .data_in         (data_in),
    .data_ready      (data_ready),
    .stop_packet_send(stop_packet_send),
    .packet_valid_o  (packet_valid_o),
    .packet_out      (packet_out),
    .err_o           (err_o),
    .busy            (busy)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  // Request, load payload from pay[] (gap idle cycles before each byte), then check the frame.
  task automatic run_frame(input logic [1:0] dest, input logic [4:0] len, input int gap,
                           input int stall_at, input int stall_n);
    int n;
    int len_i;
    logic [7:0] par;
    len_i = int'(len);
    req_valid = 1'b1;
    req_dest  = dest;
    req_len   = len;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    tick;
    req_valid = 1'b0;
    chk("busy_load", 32'(busy), 32'd1);
    chk("data_ready_load", 32'(data_ready), 32'd1);
    chk("req_ready_load", 32'(req_ready), 32'd0);
    for (int i = 0; i < len_i; i++) begin
      for (int g = 0; g < gap; g++) begin
        data_valid = 1'b0;
        tick;
        chk("no_hdr_in_gap", 32'(packet_valid_o), 32'd0);
      end
      data_valid = 1'b1;
      data_in    = pay[i];
      chk("pv_low_load", 32'(packet_valid_o), 32'd0);
      tick;
    end
    data_valid = 1'b0;

    exp_b[0] = {6'd0, dest};
    exp_b[1] = {3'd0, len};
    par = exp_b[0] ^ exp_b[1];
    for (int i = 0; i < len_i; i++) begin
      exp_b[i+2] = pay[i];
      par = par ^ pay[i];
    end
    n = len_i + 2;
`ifdef PACKET_PARITY_EN
    exp_b[n] = par;
    n++;
`endif

    for (int k = 0; k < n; k++) begin
      chk($sformatf("pv_byte%0d", k), 32'(packet_valid_o), 32'd1);
      chk($sformatf("out_byte%0d", k), 32'(packet_out), 32'(exp_b[k]));
      if (k == stall_at) begin
        stop_packet_send = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          tick;
          chk("pv_stall", 32'(packet_valid_o), 32'd1);
          chk("out_stall", 32'(packet_out), 32'(exp_b[k]));
        end
        stop_packet_send = 1'b0;
      end
      tick;
    end
    chk("pv_after_frame", 32'(packet_valid_o), 32'd0);
    chk("req_ready_after", 32'(req_ready), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic reject(input logic [1:0] dest, input logic [4:0] len, input string tag);
    req_valid = 1'b1;
    req_dest  = dest;
    req_len   = len;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    tick;
    req_valid = 1'b0;
    chk({tag, "_err"}, 32'(err_o), 32'd1);
    chk({tag, "_pv"}, 32'(packet_valid_o), 32'd0);
    chk({tag, "_ready2"}, 32'(req_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    tick;
    chk({tag, "_err_drop"}, 32'(err_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_dest = '0;
    req_len = '0;
    data_valid = 1'b0;
    data_in = '0;
    stop_packet_send = 1'b0;
    #1;
    chk("rst_pv", 32'(packet_valid_o), 32'd0);
    chk("rst_out", 32'(packet_out), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_err", 32'(err_o), 32'd0);
    tick;

    // dest 1, len 3, A1 B2 C3
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    run_frame(2'd1, 5'd3, 0, -1, 0);
    tick;

    // same frame, stall 3 cycles while B2 (index 3) is presented
    run_frame(2'd1, 5'd3, 0, 3, 3);

    reject(2'd1, 5'd0, "rej_len0");
    reject(2'd3, 5'd2, "rej_dest3");
    reject(2'd0, 5'd17, "rej_len17");

    // dest 2, len 16, payload 00..0F
    for (int i = 0; i < 16; i++) pay[i] = 8'(i);
    run_frame(2'd2, 5'd16, 0, -1, 0);

    // reset while the third payload byte is presented
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    req_valid = 1'b1;
    req_dest  = 2'd0;
    req_len   = 5'd4;
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_valid = 1'b1;
      data_in    = pay[i];
      tick;
    end
    data_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick;
    chk("pre_rst_out", 32'(packet_out), 32'h33);
    rst = 1'b1;
    #1;
    chk("midrst_pv", 32'(packet_valid_o), 32'd0);
    chk("midrst_out", 32'(packet_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_data_ready", 32'(data_ready), 32'd0);
    tick;
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", 32'(req_ready), 32'd1);
    tick;
    chk("midrst_no_trailing", 32'(packet_valid_o), 32'd0);
    pay[0] = 8'h55;
    run_frame(2'd0, 5'd1, 0, -1, 0);

    // one payload byte every 3 cycles
    pay[0] = 8'h3C; pay[1] = 8'h5A; pay[2] = 8'hF0;
    run_frame(2'd2, 5'd3, 2, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
